// File: rtl/fpga_pkg.sv
// fpga_pkg: raster constants, mood codes and sweep scheduler states shared across the ECG display path
package fpga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  typedef enum logic [1:0] {
    MOOD_CALM   = 2'd0,
    MOOD_ALERT  = 2'd1,
    MOOD_STRESS = 2'd2,
    MOOD_CRIT   = 2'd3
  } mood_t;
  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_RUN  = 2'd1,
    S_UPD  = 2'd2,
    S_HOLD = 2'd3
  } sweep_state_t;
endpackage

// File: rtl/mood_debounce.sv
// mood_debounce: commits a raw mood only after it has been seen unchanged for MOOD_HOLD update strobes
module mood_debounce
  import fpga_pkg::*;
#(
  parameter int MOOD_HOLD = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  upd,
  input  mood_t raw,
  output mood_t mood,
  output logic  chg
);
  mood_t cand;
  logic [3:0] cnt, cnt_d;
  logic commit;
  always_comb begin
    cnt_d  = (raw == cand) ? ((cnt == 4'hf) ? cnt : cnt + 4'd1) : 4'd1;
    commit = (cnt_d >= 4'(MOOD_HOLD)) && (raw != mood);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cand <= MOOD_CALM;
      cnt  <= '0;
      mood <= MOOD_CALM;
      chg  <= 1'b0;
    end else begin
      chg <= upd && commit;
      if (upd) begin
        cand <= raw;
        cnt  <= cnt_d;
        if (commit) mood <= raw;
      end
    end
  end
endmodule

// File: rtl/sweep_sched.sv
// sweep_sched: per-frame scheduler that advances the waveform scroll and debounces mood during vertical blanking
module sweep_sched
  import fpga_pkg::*;
#(
  parameter int H_ACTIVE  = fpga_pkg::H_ACTIVE,
  parameter int V_ACTIVE  = fpga_pkg::V_ACTIVE,
  parameter int STEP      = 1,
  parameter int DIV_BASE  = 8,
  parameter int MOOD_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] mood_raw,
  input  logic       pause,
  input  logic [1:0] speed,
  output logic [9:0] scroll_offset,
  output logic       sample_adv,
  output logic [1:0] mood_out,
  output logic       mood_chg,
  output logic       frame_tick,
  output logic       in_blank
);
  localparam int CW = $clog2(DIV_BASE) + 1;
  sweep_state_t state, state_d;
  logic [9:0] x_q, y_q;
  logic top_c, blank_c, top_c_q, blank_c_q, top_ev, blank_ev;
  logic upd, adv;
  logic [CW-1:0] frame_cnt, div;
  logic [10:0] sum;
  mood_t mood_q;
  // Position and condition history are free-running so edge detection is valid straight out of reset
  always_ff @(posedge clk) begin
    x_q       <= x;
    y_q       <= y;
    top_c_q   <= top_c;
    blank_c_q <= blank_c;
  end
  always_comb begin
    top_c    = (x_q == 10'd0) && (y_q == 10'd0);
    blank_c  = (x_q == 10'd0) && (y_q == 10'(V_ACTIVE));
    top_ev   = top_c && !top_c_q;
    blank_ev = blank_c && !blank_c_q;
    upd      = (state == S_UPD);
    in_blank = upd || (state == S_HOLD);
    state_d  = (state == S_SYNC || state == S_HOLD) ? (top_ev ? S_RUN : state) :
               (state == S_RUN) ? (blank_ev ? S_UPD : S_RUN) : S_HOLD;
    div      = CW'(DIV_BASE) >> speed;
    adv      = !pause && (frame_cnt >= div - CW'(1));
    sum      = {1'b0, scroll_offset} + 11'(STEP);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_SYNC;
      scroll_offset <= '0;
      frame_cnt     <= '0;
      sample_adv    <= 1'b0;
      frame_tick    <= 1'b0;
    end else begin
      state      <= state_d;
      frame_tick <= upd;
      sample_adv <= upd && adv;
      if (upd) begin
        frame_cnt <= (pause || adv) ? '0 : frame_cnt + CW'(1);
        if (adv) scroll_offset <= (sum >= 11'(H_ACTIVE)) ? 10'(sum - 11'(H_ACTIVE)) : sum[9:0];
      end
    end
  end
  mood_debounce #(.MOOD_HOLD(MOOD_HOLD)) u_mood (
    .clk  (clk),
    .reset(reset),
    .upd  (upd),
    .raw  (mood_t'(mood_raw)),
    .mood (mood_q),
    .chg  (mood_chg)
  );
  assign mood_out = mood_q;
endmodule
